// File: rtl/i2c_tx_arbiter.sv
// Round-robin arbiter that lends the single I2C transmit engine to one of NREQ
// requesters, tracks acknowledged bytes and closes each transfer with a status.
module i2c_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 1023,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic                  byte_done,
    input  logic                  byte_nack,
    output logic                  cstx,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status
);

    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_NACK    = 2'b01;
    localparam logic [1:0] STS_TIMEOUT = 2'b10;
    localparam logic [1:0] STS_ABORT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_r;
    logic [NREQ-1:0]   grant_r;
    logic [LEN_W-1:0]  byte_cnt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [ID_W-1:0]   last_id_r;
    logic [ID_W-1:0]   owner_r;
    logic              cstx_r;
    logic              busy_r;
    logic              done_r;
    logic [1:0]        status_r;

    logic [ID_W-1:0]   cand_s;
    logic [ID_W-1:0]   winner_id_s;
    logic              winner_vld_s;
    logic [LEN_W-1:0]  winner_len_s;
    logic              owner_req_s;
    logic [TO_W-1:0]   to_next_s;

    // Round-robin search; walking the offsets downward lets the nearest requester after last_id win.
    always_comb begin
        cand_s       = {ID_W{1'b0}};
        winner_id_s  = {ID_W{1'b0}};
        winner_vld_s = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            cand_s       = ID_W'((int'(last_id_r) + i) % NREQ);
            winner_id_s  = req[cand_s] ? cand_s : winner_id_s;
            winner_vld_s = winner_vld_s | req[cand_s];
        end
    end

    assign winner_len_s = req_len[int'(winner_id_s) * LEN_W +: LEN_W];
    assign owner_req_s  = |(req & grant_r);
    assign to_next_s    = (to_cnt_r == TO_W'(TIMEOUT)) ? to_cnt_r : to_cnt_r + TO_W'(1);

    // Transfer FSM: grant, byte/timeout accounting, release gap and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NREQ{1'b0}};
            byte_cnt_r <= {LEN_W{1'b0}};
            to_cnt_r   <= {TO_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            last_id_r  <= ID_W'(NREQ - 1);
            owner_r    <= {ID_W{1'b0}};
            cstx_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            status_r   <= STS_OK;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (winner_vld_s) begin
                        grant_r    <= {{(NREQ-1){1'b0}}, 1'b1} << winner_id_s;
                        owner_r    <= winner_id_s;
                        byte_cnt_r <= winner_len_s;
                        to_cnt_r   <= {TO_W{1'b0}};
                        gap_cnt_r  <= {GAP_W{1'b0}};
                        busy_r     <= 1'b1;
                        if (winner_len_s != {LEN_W{1'b0}}) begin
                            state_r <= ST_XFER;
                            cstx_r  <= 1'b1;
                        end else begin
                            // Nothing to send: close immediately without ever enabling the engine.
                            state_r  <= ST_RELEASE;
                            done_r   <= 1'b1;
                            status_r <= STS_OK;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (!owner_req_s) begin
                        state_r  <= ST_RELEASE;
                        cstx_r   <= 1'b0;
                        done_r   <= 1'b1;
                        status_r <= STS_ABORT;
                    end else if (byte_nack) begin
                        state_r  <= ST_RELEASE;
                        cstx_r   <= 1'b0;
                        done_r   <= 1'b1;
                        status_r <= STS_NACK;
                    end else if (byte_done) begin
                        byte_cnt_r <= byte_cnt_r - LEN_W'(1);
                        to_cnt_r   <= {TO_W{1'b0}};
                        if (byte_cnt_r == LEN_W'(1)) begin
                            state_r  <= ST_RELEASE;
                            cstx_r   <= 1'b0;
                            done_r   <= 1'b1;
                            status_r <= STS_OK;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end else begin
                        to_cnt_r <= to_next_s;
                        if (to_next_s == TO_W'(TIMEOUT)) begin
                            state_r  <= ST_RELEASE;
                            cstx_r   <= 1'b0;
                            done_r   <= 1'b1;
                            status_r <= STS_TIMEOUT;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end
                end
                ST_RELEASE: begin
                    last_id_r <= owner_r;
                    cstx_r    <= 1'b0;
                    if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) begin
                        state_r <= ST_IDLE;
                        grant_r <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {NREQ{1'b0}};
                    cstx_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cstx   = cstx_r;
    assign grant  = grant_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign status = status_r;

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// Directed bench for i2c_tx_arbiter: one instance with a long timeout for the
// transfer scenarios, a second with TIMEOUT=8 for the timeout scenario.
module tb_i2c_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, grant;
    logic [27:0] req_len;
    logic        byte_done, byte_nack, cstx, busy, done;
    logic [1:0]  status;

    logic [3:0]  req2, grant2;
    logic [27:0] req_len2;
    logic        byte_done2, byte_nack2, cstx2, busy2, done2;
    logic [1:0]  status2;

    int checks = 0;
    int errors = 0;
    int low_cnt;
    int n;

    i2c_tx_arbiter #(.NREQ(4), .LEN_W(7), .TIMEOUT(1023), .GAP_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
        .byte_done(byte_done), .byte_nack(byte_nack), .cstx(cstx),
        .grant(grant), .busy(busy), .done(done), .status(status)
    );

    i2c_tx_arbiter #(.NREQ(4), .LEN_W(7), .TIMEOUT(8), .GAP_CYC(2)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_len(req_len2),
        .byte_done(byte_done2), .byte_nack(byte_nack2), .cstx(cstx2),
        .grant(grant2), .busy(busy2), .done(done2), .status(status2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0; req_len = 28'd0; byte_done = 1'b0; byte_nack = 1'b0;
        req2 = 4'b0; req_len2 = 28'd0; byte_done2 = 1'b0; byte_nack2 = 1'b0;
        tick();
        tick();
        check("rst_cstx", cstx, 1'b0);
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single request, three bytes ten cycles apart
        req = 4'b0001;
        req_len[6:0] = 7'd3;
        tick();
        check("single_cstx", cstx, 1'b1);
        check("single_grant", grant, 4'b0001);
        check("single_busy", busy, 1'b1);
        for (int b = 0; b < 3; b++) begin
            repeat (9) tick();
            check("single_nodone", done, 1'b0);
            byte_done = 1'b1;
            tick();
            byte_done = 1'b0;
        end
        check("single_done", done, 1'b1);
        check("single_status", status, 2'b00);
        check("single_cstx_off", cstx, 1'b0);
        check("single_grant_hold", grant, 4'b0001);
        req = 4'b0000;
        tick();
        check("single_done_pulse", done, 1'b0);
        check("single_grant_hold2", grant, 4'b0001);
        tick();
        check("single_grant_drop", grant, 4'b0000);
        check("single_busy_drop", busy, 1'b0);

        // Round-robin among four held requests, one byte each
        do_reset();
        req_len = {7'd1, 7'd1, 7'd1, 7'd1};
        req = 4'b1111;
        low_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (cstx !== 1'b1 && n < 30) begin
                if (cstx === 1'b0) low_cnt++;
                tick();
                n++;
            end
            check("rr_cstx", cstx, 1'b1);
            check("rr_grant", grant, 4'b0001 << (i % 4));
            if (i > 0) check("rr_gap", low_cnt, 3);
            repeat (4) tick();
            byte_done = 1'b1;
            tick();
            byte_done = 1'b0;
            check("rr_done", done, 1'b1);
            check("rr_status", status, 2'b00);
            low_cnt = 0;
        end
        req = 4'b0000;
        repeat (3) tick();

        // NACK beats a same-cycle byte_done
        req_len[6:0] = 7'd4;
        req = 4'b0001;
        tick();
        check("nack_cstx", cstx, 1'b1);
        repeat (2) tick();
        byte_done = 1'b1;
        tick();
        byte_done = 1'b0;
        repeat (2) tick();
        check("nack_nodone", done, 1'b0);
        byte_done = 1'b1;
        byte_nack = 1'b1;
        tick();
        byte_done = 1'b0;
        byte_nack = 1'b0;
        check("nack_done", done, 1'b1);
        check("nack_status", status, 2'b01);
        check("nack_cstx_off", cstx, 1'b0);
        req = 4'b0000;
        repeat (3) tick();

        // Abort when the granted request drops mid-transfer
        req_len[20:14] = 7'd5;
        req = 4'b0100;
        tick();
        check("abort_grant", grant, 4'b0100);
        repeat (3) tick();
        req = 4'b0000;
        tick();
        check("abort_done", done, 1'b1);
        check("abort_status", status, 2'b11);
        check("abort_cstx", cstx, 1'b0);
        repeat (3) tick();

        // Zero length closes at once with cstx never raised
        req_len[13:7] = 7'd0;
        req = 4'b0010;
        tick();
        check("zero_grant", grant, 4'b0010);
        check("zero_done", done, 1'b1);
        check("zero_status", status, 2'b00);
        check("zero_cstx", cstx, 1'b0);
        req = 4'b0000;
        tick();
        check("zero_cstx2", cstx, 1'b0);
        check("zero_done_pulse", done, 1'b0);
        tick();
        check("zero_grant_drop", grant, 4'b0000);

        // Timeout on the TIMEOUT=8 instance
        req_len2[6:0] = 7'd2;
        req2 = 4'b0001;
        tick();
        check("to_cstx", cstx2, 1'b1);
        repeat (7) tick();
        check("to_early", done2, 1'b0);
        check("to_cstx_hold", cstx2, 1'b1);
        tick();
        check("to_done", done2, 1'b1);
        check("to_status", status2, 2'b10);
        req2 = 4'b0000;
        repeat (3) tick();

        // Asynchronous reset in the middle of a transfer
        req_len = {7'd2, 7'd2, 7'd2, 7'd3};
        req = 4'b0001;
        tick();
        tick();
        check("ar_cstx_pre", cstx, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_cstx", cstx, 1'b0);
        check("ar_grant", grant, 4'b0000);
        check("ar_done", done, 1'b0);
        check("ar_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        req = 4'b1010;
        tick();
        check("ar_regrant", grant, 4'b0010);
        check("ar_recstx", cstx, 1'b1);
        req = 4'b0000;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
